// File: rtl/dmem_arbiter.sv
// Purpose: shares one single-cycle data memory between port 0 (fixed priority) and port 1 (starvation-bounded).
// Latency: grant is combinational in the request cycle; ack and read data are registered one cycle later.
// Backpressure: a request without a grant stalls in place; port 1 is forced through after MAXWAIT stalled cycles.
module dmem_arbiter #(
   parameter int unsigned MAXWAIT = 3
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req0,
   input  logic        req1,
   input  logic        we0,
   input  logic        we1,
   input  logic [31:0] a0,
   input  logic [31:0] a1,
   input  logic [31:0] wd0,
   input  logic [31:0] wd1,
   output logic        gnt0,
   output logic        gnt1,
   output logic        ack0,
   output logic        ack1,
   output logic [31:0] rd0,
   output logic [31:0] rd1,
   output logic        mem_we,
   output logic [31:0] mem_a,
   output logic [31:0] mem_wd,
   input  logic [31:0] mem_rd
);

   localparam logic [3:0] MAXW = 4'(MAXWAIT);

   // Consecutive stalled cycles of the current port-1 request.
   logic [3:0] wcnt;
   logic       force1;

   // Arbitration: port 1 wins when port 0 is idle or when its wait has run out.
   // Grants are suppressed in reset so a request in the reset cycle is dropped.
   always_comb begin
      force1 = req1 & (wcnt == MAXW);
      gnt1   = ~reset & req1 & (~req0 | force1);
      gnt0   = ~reset & req0 & ~gnt1;
   end

   // Memory steering: the granted port drives the memory, port 0 owns the bus when idle.
   always_comb begin
      mem_we = (gnt0 & we0) | (gnt1 & we1);
      mem_a  = gnt1 ? a1  : a0;
      mem_wd = gnt1 ? wd1 : wd0;
   end

   // Wait counter: clears on a port-1 grant or when port 1 drops its request, saturates at MAXWAIT.
   always_ff @(posedge clk) begin
      if (reset || gnt1 || !req1) begin
         wcnt <= 4'd0;
      end else if (wcnt != MAXW) begin
         wcnt <= wcnt + 4'd1;
      end
   end

   // Acknowledge: one pulse the cycle after each granted access.
   always_ff @(posedge clk) begin
      if (reset) begin
         ack0 <= 1'b0;
         ack1 <= 1'b0;
      end else begin
         ack0 <= gnt0;
         ack1 <= gnt1;
      end
   end

   // Read data: captured only for granted reads, otherwise held so a write ack leaves it intact.
   always_ff @(posedge clk) begin
      if (reset) begin
         rd0 <= 32'd0;
         rd1 <= 32'd0;
      end else begin
         if (gnt0 && !we0) rd0 <= mem_rd;
         if (gnt1 && !we1) rd1 <= mem_rd;
      end
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios followed by randomized traffic.
// A driver predicts grants, memory effects and next-cycle acks/read data; a monitor compares them.
module tb_dmem_arbiter;

   localparam int MAXWAIT = 3;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
   logic [31:0] a0 = '0, a1 = '0, wd0 = '0, wd1 = '0;
   logic        gnt0, gnt1, ack0, ack1, mem_we;
   logic [31:0] rd0, rd1, mem_a, mem_wd, mem_rd;

   dmem_arbiter #(.MAXWAIT(MAXWAIT)) dut (
      .clk(clk), .reset(reset),
      .req0(req0), .req1(req1), .we0(we0), .we1(we1),
      .a0(a0), .a1(a1), .wd0(wd0), .wd1(wd1),
      .gnt0(gnt0), .gnt1(gnt1), .ack0(ack0), .ack1(ack1),
      .rd0(rd0), .rd1(rd1),
      .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd), .mem_rd(mem_rd)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // The shared data memory: 64 words, combinational read, write on the rising edge.
   logic [31:0] mem [0:63];
   assign mem_rd = mem[mem_a[7:2]];
   always @(posedge clk) if (mem_we) mem[mem_a[7:2]] <= mem_wd;

   // Reference model state.
   logic [31:0] ref_mem [0:63];
   logic [31:0] model_rd0 = '0, model_rd1 = '0;
   int          stall1 = 0;
   logic        pend0 = 1'b0, pend1 = 1'b0;

   typedef struct {
      int          cyc;
      logic        ack0;
      logic        ack1;
      logic [31:0] rd0;
      logic [31:0] rd1;
   } exp_t;
   exp_t sb[$];

   int errors = 0;
   int checks = 0;
   int we20_cnt = 0;
   int ack1_cnt = 0;
   int gnt1_cnt = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
      end
   endtask

   // One bus cycle: drive inputs, predict the arbiter's decision from the rules, check the
   // combinational outputs, update the model and queue what must appear next cycle.
   task automatic drive(input logic rst,
                        input logic r0, input logic w0, input logic [31:0] x0, input logic [31:0] d0,
                        input logic r1, input logic w1, input logic [31:0] x1, input logic [31:0] d1);
      logic g0, g1, exp_we;
      exp_t e;
      @(negedge clk);
      reset = rst;
      req0 = r0; we0 = w0; a0 = x0; wd0 = d0;
      req1 = r1; we1 = w1; a1 = x1; wd1 = d1;
      #1;
      if (rst) begin
         g0 = 1'b0;
         g1 = 1'b0;
      end else begin
         g1 = r1 && (!r0 || stall1 >= MAXWAIT);
         g0 = r0 && !g1;
      end
      exp_we = (g0 && w0) || (g1 && w1);
      check("grant", {30'd0, gnt0, gnt1}, {30'd0, g0, g1});
      check("mem_we", {31'd0, mem_we}, {31'd0, exp_we});
      check("mem_a", mem_a, g1 ? x1 : x0);
      check("mem_wd", mem_wd, g1 ? d1 : d0);
      if (mem_we && mem_a == 32'h20) we20_cnt++;
      if (ack1) ack1_cnt++;
      if (gnt1) gnt1_cnt++;
      if (rst) begin
         stall1 = 0;
         model_rd0 = '0;
         model_rd1 = '0;
      end else begin
         if (g1 || !r1) stall1 = 0;
         else stall1++;
         if (g0) begin
            if (w0) ref_mem[x0[7:2]] = d0;
            else model_rd0 = ref_mem[x0[7:2]];
         end
         if (g1) begin
            if (w1) ref_mem[x1[7:2]] = d1;
            else model_rd1 = ref_mem[x1[7:2]];
         end
      end
      pend0 = r0 && !g0;
      pend1 = r1 && !g1;
      e.cyc  = cyc + 1;
      e.ack0 = g0;
      e.ack1 = g1;
      e.rd0  = model_rd0;
      e.rd1  = model_rd1;
      sb.push_back(e);
   endtask

   task automatic idle();
      drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
   endtask

   // Monitor: every cycle the registered outputs are compared against the queued prediction.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            check("sb_cycle", cyc, e.cyc);
            check("ack0", {31'd0, ack0}, {31'd0, e.ack0});
            check("ack1", {31'd0, ack1}, {31'd0, e.ack1});
            check("rd0", rd0, e.rd0);
            check("rd1", rd1, e.rd1);
         end
      end
   end

   initial begin
      logic        r0, w0, r1, w1;
      logic [31:0] x0, d0, x1, d1;
      logic [31:0] before10;

      for (int i = 0; i < 64; i++) begin
         mem[i]     <= 32'h1000_0000 + 32'(i * 7);
         ref_mem[i]  = 32'h1000_0000 + 32'(i * 7);
      end
      mem[17]     <= 32'h1234_5678;
      ref_mem[17]  = 32'h1234_5678;

      // Reset, with a request present that must be ignored.
      drive(1'b1, 1'b1, 1'b1, 32'h4, 32'h1, 1'b0, 1'b0, 32'h0, 32'h0);
      drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);

      // Port 0 alone: write then read back.
      drive(1'b0, 1'b1, 1'b1, 32'h40, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0, 32'h0);
      drive(1'b0, 1'b1, 1'b0, 32'h40, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
      idle();

      // Port 1 alone: read a preloaded word.
      drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h44, 32'h0);
      idle();

      // Continuous contention: port 1 must get every fourth cycle.
      gnt1_cnt = 0;
      for (int i = 0; i < 12; i++)
         drive(1'b0, 1'b1, 1'b0, 32'h40, 32'h0, 1'b1, 1'b0, 32'h44, 32'h0);
      check("contention_gnt1_count", gnt1_cnt, 3);
      idle();

      // Read-after-write across ports in consecutive cycles.
      drive(1'b0, 1'b1, 1'b1, 32'h80, 32'hA5A5A5A5, 1'b0, 1'b0, 32'h0, 32'h0);
      drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h80, 32'h0);
      idle();

      // Build up wait count, then reset in the cycle port 1 would write 0x10.
      before10 = ref_mem[4];
      drive(1'b0, 1'b1, 1'b0, 32'h40, 32'h0, 1'b1, 1'b0, 32'h44, 32'h0);
      drive(1'b0, 1'b1, 1'b0, 32'h40, 32'h0, 1'b1, 1'b0, 32'h44, 32'h0);
      drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h10, 32'h55);

      // Held port-1 write stalled for two cycles, then granted once.
      we20_cnt = 0;
      ack1_cnt = 0;
      drive(1'b0, 1'b1, 1'b0, 32'h40, 32'h0, 1'b1, 1'b1, 32'h20, 32'hCAFE0020);
      drive(1'b0, 1'b1, 1'b0, 32'h48, 32'h0, 1'b1, 1'b1, 32'h20, 32'hCAFE0020);
      drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h20, 32'hCAFE0020);
      idle();
      idle();
      check("reset_no_write_0x10", mem[4], before10);
      check("stall_we_pulses", we20_cnt, 1);
      check("stall_ack1_pulses", ack1_cnt, 1);
      check("stall_write_data", mem[8], 32'hCAFE0020);

      // Randomized traffic; a stalled request is held unchanged until granted.
      r0 = 0; w0 = 0; x0 = 0; d0 = 0; r1 = 0; w1 = 0; x1 = 0; d1 = 0;
      for (int i = 0; i < 600; i++) begin
         if (!pend0) begin
            r0 = ($urandom % 4) != 0;
            w0 = $urandom % 2;
            x0 = 32'($urandom_range(0, 255));
            d0 = $urandom;
         end
         if (!pend1) begin
            r1 = ($urandom % 3) != 0;
            w1 = $urandom % 2;
            x1 = 32'($urandom_range(0, 255));
            d1 = $urandom;
         end
         drive(1'b0, r0, w0, x0, d0, r1, w1, x1, d1);
      end
      idle();
      @(negedge clk);
      #2;
      check("scoreboard_drained", 32'(sb.size()), 32'd0);
      for (int i = 0; i < 64; i++) check("final_mem", mem[i], ref_mem[i]);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-requester arbiter that shares the single data memory (`dmem`: combinational read, write on rising edge, word-addressed by a[31:2]) between the processor data port (port 0) and a secondary master such as a loader or DMA engine (port 1). Port 0 has fixed priority, and a wait counter bounds starvation of port 1. Each granted access completes in one memory cycle. The result is returned with a registered acknowledge and registered read data one cycle later. The block sits between the two masters and `dmem`, and drives the memory's we/a/wd and samples its rd.

## Interface
- MAXWAIT, 3: consecutive stalled cycles of a pending port-1 request, after which port 1 is forced a grant over port 0; legal range 1..15.
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- req0, req1  in  1  access request from port 0 / port 1, level-sensitive.
- we0, we1  in  1  1 = write, 0 = read; qualified by reqN.
- a0, a1  in  32  byte address; bits [1:0] are passed through and ignored by memory.
- wd0, wd1  in  32  write data.
- gnt0, gnt1  out  1  combinational grant for the current cycle; at most one is high.
- ack0, ack1  out  1  registered: high for one cycle after a granted access of that port.
- rd0, rd1  out  32  registered read data; valid when ackN=1 for a read; holds its last value otherwise.
- mem_we  out  1  memory write enable = gnt0&we0 | gnt1&we1.
- mem_a, mem_wd  out  32  address and write data of the granted port; port-0 values when idle.
- mem_rd  in  32  memory read data, combinational from mem_a.

## Operation
- State:
  - wait counter wcnt, 4 bits, saturating at MAXWAIT;
  - ack0/ack1 registers;
  - rd0/rd1 registers.
- Grant, evaluated each cycle:
  - force1 = req1 & (wcnt == MAXWAIT).
  - gnt1 = req1 & (~req0 | force1).
  - gnt0 = req0 & ~gnt1.
- wcnt update:
  - 0 if reset or gnt1 or ~req1;
  - otherwise, when req1 & ~gnt1, wcnt increments, saturating at MAXWAIT.
- At each posedge, for N in {0,1}:
  - ackN <= gntN.
  - If gntN & ~weN, rdN <= mem_rd.
  - A write commits to memory at the same edge.
- Requester protocol:
  - Hold reqN, weN, aN and wdN stable while reqN=1 and gntN=0.
  - reqN high in the cycle ackN is high is a new request (pipelined issue), so a continuous request receives one access per granted cycle.
- A stalled request (reqN=1, gntN=0) is not lost. It is re-arbitrated every cycle until granted.
- Only one access per cycle, so there are no same-address races. A write granted in cycle N is visible to any read granted in cycle N+1.
- Reset:
  - ack0=ack1=0, rd0=rd1=0, wcnt=0.
  - gnt0, gnt1 and mem_we are forced 0 while reset=1, so no write occurs during reset.
  - reset mid-access: an access granted in the reset cycle is dropped, with no ack and no write.

## Timing
- Grant: combinational, same cycle as the request.
- Request-to-ack latency: 1 cycle when uncontended.
- Port-1 worst-case latency under a continuous req0: MAXWAIT stalled cycles, then a grant, then the ack next cycle (MAXWAIT+1 cycles to ack).
- After a forced port-1 grant, wcnt returns to 0 and port 0 regains priority the next cycle. Port 0 is stalled for exactly that one cycle.
- rdN changes only on the edge that raises ackN for a read. A write ack leaves rdN unchanged.
- Throughput: one memory access per cycle when any request is pending.

## Test plan
- Port-0 only: write 0xDEADBEEF to 0x40, then read 0x40 -> gnt0 in both cycles; ack0 follows each by 1 cycle; rd0=0xDEADBEEF with the second ack0; gnt1, ack1 and rd1 stay 0.
- Port-1 only: read 0x44 (preloaded 0x12345678) -> gnt1 same cycle, ack1 next, rd1=0x12345678; rd0 unchanged.
- Contention, MAXWAIT=3: req0 and req1 held high continuously -> grant pattern 0,0,0,1,0,0,0,1,...; every fourth cycle port 1 is granted; wcnt sequence 1,2,3,0.
- Read-after-write across ports: port 0 writes 0xA5A5A5A5 to 0x80 in cycle N, port 1 reads 0x80 in cycle N+1 -> rd1=0xA5A5A5A5 with ack1 in cycle N+2.
- Reset mid-operation: assert reset in the cycle port 1 writes 0x55 to 0x10 -> mem_we=0 that cycle, no ack1, memory at 0x10 unchanged; all acks 0, rd0=rd1=0, wcnt=0 after the edge.
- Stall stability: port 1 holds a write to 0x20 for two stalled cycles, then is granted -> exactly one mem_we pulse with a=0x20 and exactly one ack1.
